// File: rtl/dsram_pkg.sv
// rtl/dsram_pkg.sv - shared types and constants for the dsram_pipe data RAM
package dsram_pkg;

    localparam int LANE_W = 8;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_INIT  = 2'd1,
        ST_RUN   = 2'd2
    } dsram_state_t;

    function automatic int dsram_latency(input int oreg);
        return 1 + oreg;
    endfunction

endpackage

// File: rtl/dsram_lane.sv
// rtl/dsram_lane.sv - one byte lane: 2^AW x 8 array with registered read-first port
module dsram_lane
    import dsram_pkg::*;
#(
    parameter int AW = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic [AW-1:0]     addr,
    input  logic [LANE_W-1:0] wdata,
    output logic [LANE_W-1:0] rdata
);

    logic [LANE_W-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Read register sees the pre-write contents when read and write share an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dsram_pipe.sv
// rtl/dsram_pipe.sv - byte-lane data SRAM with valid/ready requests, fixed-latency reads and zero-fill
module dsram_pipe
    import dsram_pkg::*;
#(
    parameter int AW        = 16,
    parameter int BW        = 4,
    parameter int OREG      = 0,
    parameter int INIT_ZERO = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [BW-1:0]        req_ben,
    input  logic [AW-1:0]        req_addr,
    input  logic [BW*LANE_W-1:0] req_wdata,
    output logic                 rsp_valid,
    output logic [BW*LANE_W-1:0] rsp_rdata,
    output logic                 init_done
);

    localparam int L  = dsram_latency(OREG);
    localparam int DW = BW * LANE_W;

    dsram_state_t  state_q;
    dsram_state_t  state;
    logic [AW-1:0] fill_addr;
    logic [L-1:0]  vpipe;
    logic          filling;
    logic          rd_acc;
    logic          wr_acc;
    logic [BW-1:0] lane_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] lane_rdata;
    logic [DW-1:0] data_sel;

    // RESET is simply "rst is high"; the register holds where to go once it drops.
    always_comb state = rst ? ST_RESET : state_q;

    assign req_ready = (state == ST_RUN);
    assign init_done = (state == ST_RUN);
    assign filling   = (state == ST_INIT);
    assign wr_acc    = req_valid & req_ready & req_we;
    assign rd_acc    = req_valid & req_ready & ~req_we;

    assign lane_we   = filling ? {BW{1'b1}} : (wr_acc ? req_ben : '0);
    assign mem_addr  = filling ? fill_addr : req_addr;
    assign mem_wdata = filling ? '0 : req_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= (INIT_ZERO != 0) ? ST_INIT : ST_RUN;
            fill_addr <= '0;
            vpipe     <= '0;
        end else begin
            if (filling) begin
                fill_addr <= fill_addr + 1'b1;
                if (fill_addr == '1) begin
                    state_q <= ST_RUN;
                end
            end
            vpipe <= (vpipe << 1) | L'(rd_acc);
        end
    end

    for (genvar i = 0; i < BW; i++) begin : g_lane
        dsram_lane #(.AW(AW)) u_lane (
            .clk   (clk),
            .rst   (rst),
            .we    (lane_we[i]),
            .re    (rd_acc),
            .addr  (mem_addr),
            .wdata (mem_wdata[i*LANE_W +: LANE_W]),
            .rdata (lane_rdata[i*LANE_W +: LANE_W])
        );
    end

    if (OREG != 0) begin : g_oreg
        logic [DW-1:0] out_q;
        always_ff @(posedge clk) begin
            if (rst) begin
                out_q <= '0;
            end else if (vpipe[0]) begin
                out_q <= lane_rdata;
            end
        end
        assign data_sel = out_q;
    end else begin : g_no_oreg
        assign data_sel = lane_rdata;
    end

    assign rsp_valid = vpipe[L-1] & ~rst;
    assign rsp_rdata = rst ? '0 : data_sel;

endmodule
